// File: rtl/crc16_seq_pkg.sv
// Shared definitions for the CRC-16 sequencer: state encoding, CRC width,
// the residue a good packet leaves in the engine, and parameter defaults.
package crc16_seq_pkg;

  localparam int CRC_W          = 16;
  localparam logic [CRC_W-1:0] CRC_RESIDUE = 16'h1D0F;
  localparam int LEN_W_DEF      = 8;
  localparam int MIN_RX_LEN_DEF = 17;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLR     = 3'd1,
    ST_RX      = 3'd2,
    ST_RX_CHK1 = 3'd3,
    ST_RX_CHK2 = 3'd4,
    ST_TX_PAY  = 3'd5,
    ST_TX_CRC  = 3'd6
  } state_t;

endpackage

// File: rtl/crc16_ser.sv
// CRC serialiser: captures the engine's complemented CRC on the first
// enabled cycle and emits it MSB-first over 16 consecutive enabled cycles.
// The first bit is taken straight from din so the engine's final value
// (updated by the last payload bit on the same edge that enters this
// phase) is used without a gap cycle.
module crc16_ser
  import crc16_seq_pkg::*;
(
  input  logic             clk_crc16,
  input  logic             rst_crc16,
  input  logic             en,
  input  logic [CRC_W-1:0] din,
  output logic             bit_o,
  output logic             last_o
);

  logic [CRC_W-1:0] sr;
  logic [3:0]       cnt;

  // Current output bit and last-bit flag.
  always_comb begin
    bit_o  = (cnt == 4'd0) ? din[CRC_W-1] : sr[CRC_W-1];
    last_o = en && (cnt == 4'd15);
  end

  // Load on the first enabled cycle, shift left afterwards; cnt wraps to 0.
  always_ff @(posedge clk_crc16 or negedge rst_crc16) begin
    if (!rst_crc16) begin
      sr  <= '0;
      cnt <= '0;
    end else if (en) begin
      sr  <= (cnt == 4'd0) ? (din << 1) : (sr << 1);
      cnt <= cnt + 4'd1;
    end
  end

endmodule

// File: rtl/crc16_seq.sv
// CRC-16 sequencer: owns the shared CRC engine, clears it between packets,
// feeds it received command bits (then triggers the residue check) or reply
// payload bits (then serialises the complemented CRC after the payload).
//
// Handshakes: rx_valid is a one-cycle strobe with no back-pressure; a bit is
// consumed exactly when rx_valid=1 in RX and the packet is not yet full.
// On the reply side tx_rd=1 marks the cycle in which tx_bit is consumed, so
// tx_bit must already be valid in that cycle; there are no stalls.
module crc16_seq
  import crc16_seq_pkg::*;
#(
  parameter int LEN_W      = LEN_W_DEF,
  parameter int MIN_RX_LEN = MIN_RX_LEN_DEF
) (
  input  logic             clk_crc16,
  input  logic             rst_crc16,
  input  logic             rx_start,
  input  logic [LEN_W-1:0] rx_len,
  input  logic             rx_len_valid,
  input  logic             rx_bit,
  input  logic             rx_valid,
  input  logic             rx_abort,
  input  logic             tx_start,
  input  logic [LEN_W-1:0] tx_len,
  input  logic             tx_bit,
  output logic             tx_rd,
  output logic             tx_out,
  output logic             tx_out_valid,
  output logic             tx_done,
  output logic             tx_reject,
  output logic             rx_done,
  output logic             rx_pass,
  output logic             busy,
  output logic             crc_rst_n,
  output logic             crc_data,
  output logic             crc_sync,
  output logic             crc_reply_data,
  output logic             crc_en_rpy,
  output logic             crc_pkg_complete,
  input  logic [CRC_W-1:0] crc_16,
  input  logic             crc_pass,
  output state_t           dbg_state
);

  localparam logic [LEN_W-1:0] MIN_LEN = LEN_W'(MIN_RX_LEN);
  localparam logic [LEN_W-1:0] CNT_MAX = '1;
  localparam logic [LEN_W-1:0] ONE     = LEN_W'(1);

  state_t           state, next_state;
  logic             tgt_tx_q;
  logic             len_known;
  logic [LEN_W-1:0] len_q, tx_len_q, bit_cnt;

  logic             eff_known, rx_short, rx_take, rx_full, pay_last;
  logic [LEN_W-1:0] eff_len, cnt_inc;
  logic             ser_en, ser_bit, ser_last;
  logic             tx_out_d, tx_out_valid_d, tx_done_d, tx_reject_d;
  logic             rx_done_d, rx_pass_d, crc_rst_n_d;

  crc16_ser u_ser (
    .clk_crc16 (clk_crc16),
    .rst_crc16 (rst_crc16),
    .en        (ser_en),
    .din       (crc_16),
    .bit_o     (ser_bit),
    .last_o    (ser_last)
  );

  // Receive bookkeeping: length known this cycle, bit acceptance, saturating count.
  always_comb begin
    eff_known = len_known | rx_len_valid;
    eff_len   = rx_len_valid ? rx_len : len_q;
    rx_short  = (state == ST_RX) && eff_known && (eff_len < MIN_LEN);
    rx_take   = (state == ST_RX) && rx_valid && !rx_abort && !rx_short &&
                !(eff_known && (bit_cnt >= eff_len));
    cnt_inc   = bit_cnt;
    if (rx_take && (bit_cnt != CNT_MAX)) cnt_inc = bit_cnt + ONE;
    rx_full   = eff_known && (cnt_inc >= eff_len);
    pay_last  = ((bit_cnt + ONE) == tx_len_q);
  end

  // State register.
  always_ff @(posedge clk_crc16 or negedge rst_crc16) begin
    if (!rst_crc16) state <= ST_IDLE;
    else            state <= next_state;
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:    if (rx_start || tx_start) next_state = ST_CLR;
      ST_CLR:     if (!tgt_tx_q)            next_state = ST_RX;
                  else if (tx_len_q == '0)  next_state = ST_TX_CRC;
                  else                      next_state = ST_TX_PAY;
      ST_RX:      if (rx_abort || rx_short) next_state = ST_IDLE;
                  else if (rx_full)         next_state = ST_RX_CHK1;
      ST_RX_CHK1: next_state = rx_abort ? ST_IDLE : ST_RX_CHK2;
      ST_RX_CHK2: next_state = ST_IDLE;
      ST_TX_PAY:  if (pay_last)             next_state = ST_TX_CRC;
      ST_TX_CRC:  if (ser_last)             next_state = ST_IDLE;
      default:    next_state = ST_IDLE;
    endcase
  end

  // Output decode: engine controls directly, registered outputs via *_d.
  always_comb begin
    busy             = (state != ST_IDLE);
    tx_rd            = (state == ST_TX_PAY);
    crc_en_rpy       = (state == ST_TX_PAY);
    crc_reply_data   = (state == ST_TX_PAY) && tx_bit;
    crc_sync         = rx_take;
    crc_data         = rx_take && rx_bit;
    crc_pkg_complete = (state == ST_RX_CHK1);
    ser_en           = (state == ST_TX_CRC);
    tx_out_d         = 1'b0;
    if (state == ST_TX_PAY)      tx_out_d = tx_bit;
    else if (state == ST_TX_CRC) tx_out_d = ser_bit;
    tx_out_valid_d   = (state == ST_TX_PAY) || (state == ST_TX_CRC);
    tx_done_d        = ser_last;
    tx_reject_d      = tx_start && ((state != ST_IDLE) || rx_start);
    rx_done_d        = ((state == ST_RX) && (rx_abort || rx_short)) ||
                       ((state == ST_RX_CHK1) && rx_abort) ||
                       (state == ST_RX_CHK2);
    rx_pass_d        = (state == ST_RX_CHK2) && !rx_abort && crc_pass;
    crc_rst_n_d      = (next_state != ST_CLR);
  end

  // Packet context: target of the clear, lengths and bit counter.
  always_ff @(posedge clk_crc16 or negedge rst_crc16) begin
    if (!rst_crc16) begin
      tgt_tx_q  <= 1'b0;
      len_known <= 1'b0;
      len_q     <= '0;
      tx_len_q  <= '0;
      bit_cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          bit_cnt   <= '0;
          len_known <= 1'b0;
          if (rx_start) begin
            tgt_tx_q <= 1'b0;
          end else if (tx_start) begin
            tgt_tx_q <= 1'b1;
            tx_len_q <= tx_len;
          end
        end
        ST_CLR, ST_RX: begin
          if (rx_len_valid && !tgt_tx_q) begin
            len_q     <= rx_len;
            len_known <= 1'b1;
          end
          if (state == ST_RX) bit_cnt <= cnt_inc;
        end
        ST_TX_PAY: bit_cnt <= bit_cnt + ONE;
        default:   bit_cnt <= bit_cnt;
      endcase
    end
  end

  // Registered outputs; rx_pass holds its value between rx_done pulses.
  always_ff @(posedge clk_crc16 or negedge rst_crc16) begin
    if (!rst_crc16) begin
      tx_out       <= 1'b0;
      tx_out_valid <= 1'b0;
      tx_done      <= 1'b0;
      tx_reject    <= 1'b0;
      rx_done      <= 1'b0;
      rx_pass      <= 1'b0;
      crc_rst_n    <= 1'b1;
    end else begin
      tx_out       <= tx_out_d;
      tx_out_valid <= tx_out_valid_d;
      tx_done      <= tx_done_d;
      tx_reject    <= tx_reject_d;
      rx_done      <= rx_done_d;
      if (rx_done_d) rx_pass <= rx_pass_d;
      crc_rst_n    <= crc_rst_n_d;
    end
  end

  assign dbg_state = state;

endmodule
